// File: rtl/gnn_0_example_buf_rd_arb.sv
// gnn_0_example_buf_rd_arb
//   Two-requester round-robin read arbiter in front of a shared buffer.
//   Accepted reads are forwarded one cycle later. The requester id is
//   queued in an in-order tag FIFO so that returns, which arrive in
//   request order at a fixed latency, can be steered to the right requester.
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   reqN_avalid/addr      read request from requester N (0 = save, 1 = compute)
//   reqN_aready           combinational accept for requester N
//   reqN_valid/data       registered one-cycle return pulse and data
//   buf_avalid/addr       registered read request to the shared buffer
//   buf_valid/data        in-order return from the buffer
//   err_unexp             sticky: a return arrived with nothing outstanding
//   grant_cnt0/1          per-requester acceptance counters
//
// Configuration
//   GNN_BUF_RD_ARB_PERF_EN  defined: saturating 32-bit grant counters.
//                           undefined: grant_cnt0/1 tied to 0.
module gnn_0_example_buf_rd_arb #(
  parameter int C_BUF_ADDR_WIDTH  = 11,
  parameter int C_BUF_DATA_WIDTH  = 512,
  parameter int C_MAX_OUTSTANDING = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        req0_avalid,
  input  logic [C_BUF_ADDR_WIDTH-1:0] req0_addr,
  output logic                        req0_aready,
  output logic                        req0_valid,
  output logic [C_BUF_DATA_WIDTH-1:0] req0_data,
  input  logic                        req1_avalid,
  input  logic [C_BUF_ADDR_WIDTH-1:0] req1_addr,
  output logic                        req1_aready,
  output logic                        req1_valid,
  output logic [C_BUF_DATA_WIDTH-1:0] req1_data,
  output logic                        buf_avalid,
  output logic [C_BUF_ADDR_WIDTH-1:0] buf_addr,
  input  logic                        buf_valid,
  input  logic [C_BUF_DATA_WIDTH-1:0] buf_data,
  output logic                        err_unexp,
  output logic [31:0]                 grant_cnt0,
  output logic [31:0]                 grant_cnt1
);

  localparam int PW = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(C_MAX_OUTSTANDING);

  logic                         rr_q, rr_d;
  logic [OW-1:0]                occ_q, occ_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [C_MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic                         buf_avalid_q, buf_avalid_d;
  logic [C_BUF_ADDR_WIDTH-1:0]  buf_addr_q, buf_addr_d;
  logic                         req0_valid_q, req0_valid_d;
  logic                         req1_valid_q, req1_valid_d;
  logic [C_BUF_DATA_WIDTH-1:0]  req0_data_q, req0_data_d;
  logic [C_BUF_DATA_WIDTH-1:0]  req1_data_q, req1_data_d;
  logic                         err_q, err_d;

  logic room, win1, acc0, acc1, acc, ret, ret_tag;

  // Gate with areset so aready reads 0 throughout reset.
  assign room    = (occ_q < OCC_MAX);
  assign win1    = req1_avalid & (~req0_avalid | rr_q);
  assign acc1    = ~areset & room & win1;
  assign acc0    = ~areset & room & req0_avalid & ~win1;
  assign acc     = acc0 | acc1;
  // occ tracks the FIFO fill, so occ != 0 means a tag is available to pop.
  assign ret     = buf_valid & (occ_q != '0);
  assign ret_tag = tag_q[rd_ptr_q];

  always_comb begin
    rr_d         = rr_q;
    occ_d        = occ_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_d        = tag_q;
    buf_avalid_d = acc;
    buf_addr_d   = buf_addr_q;
    req0_valid_d = ret & ~ret_tag;
    req1_valid_d = ret & ret_tag;
    req0_data_d  = req0_data_q;
    req1_data_d  = req1_data_q;
    err_d        = err_q | (buf_valid & (occ_q == '0));

    if (acc) begin
      rr_d             = ~win1;              // point at the loser
      tag_d[wr_ptr_q]  = win1;
      wr_ptr_d         = wr_ptr_q + PW'(1);
      buf_addr_d       = win1 ? req1_addr : req0_addr;
    end
    if (ret) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (ret_tag) req1_data_d = buf_data;
      else         req0_data_d = buf_data;
    end
    case ({acc, ret})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_q         <= 1'b0;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_q        <= '0;
      buf_avalid_q <= 1'b0;
      buf_addr_q   <= '0;
      req0_valid_q <= 1'b0;
      req1_valid_q <= 1'b0;
      req0_data_q  <= '0;
      req1_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_q        <= tag_d;
      buf_avalid_q <= buf_avalid_d;
      buf_addr_q   <= buf_addr_d;
      req0_valid_q <= req0_valid_d;
      req1_valid_q <= req1_valid_d;
      req0_data_q  <= req0_data_d;
      req1_data_q  <= req1_data_d;
      err_q        <= err_d;
    end
  end

  assign req0_aready = acc0;
  assign req1_aready = acc1;
  assign buf_avalid  = buf_avalid_q;
  assign buf_addr    = buf_addr_q;
  assign req0_valid  = req0_valid_q;
  assign req1_valid  = req1_valid_q;
  assign req0_data   = req0_data_q;
  assign req1_data   = req1_data_q;
  assign err_unexp   = err_q;

`ifdef GNN_BUF_RD_ARB_PERF_EN
  logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 32'd1;
    if (acc1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = 32'd0;
  assign grant_cnt1 = 32'd0;
`endif

endmodule

// File: doc/gnn_0_example_buf_rd_arb.md
GNN_0_EXAMPLE_BUF_RD_ARB -- requirements
Module: gnn_0_example_buf_rd_arb

Interface
REQ-001 The block SHALL run on one clock, aclk; reset SHALL be areset, synchronous and active-high.
REQ-002 The block SHALL have these parameters:
- C_BUF_ADDR_WIDTH, default 11, buffer word address width.
- C_BUF_DATA_WIDTH, default 512, buffer word width.
- C_MAX_OUTSTANDING, default 8, power of two, maximum in-flight reads.
REQ-003 The block SHALL have these ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- req0_avalid  in  1  requester 0 (save path) read request.
- req0_addr  in  C_BUF_ADDR_WIDTH  requester 0 read address.
- req0_aready  out  1  requester 0 request accepted this cycle.
- req0_valid  out  1  requester 0 return data valid.
- req0_data  out  C_BUF_DATA_WIDTH  requester 0 return data.
- req1_avalid, req1_addr, req1_aready, req1_valid, req1_data  same as requester 0, for requester 1 (compute path).
- buf_avalid  out  1  shared buffer read request.
- buf_addr  out  C_BUF_ADDR_WIDTH  shared buffer read address.
- buf_valid  in  1  buffer return valid; returns arrive in request order, at fixed but unknown latency.
- buf_data  in  C_BUF_DATA_WIDTH  buffer return data.
- err_unexp  out  1  sticky flag: a return arrived with no read outstanding.
- grant_cnt0, grant_cnt1  out  32 each  performance counters (see Configuration).

Function
REQ-010 Request N SHALL be accepted when reqN_avalid=1, reqN_aready=1 and a rising edge of aclk occurs.
REQ-011 reqN_aready SHALL be combinational: it is 1 only when reqN_avalid=1, requester N wins arbitration, and occ < C_MAX_OUTSTANDING.
REQ-012 When only one requester asserts avalid, that requester SHALL win.
REQ-013 When both requesters assert avalid, the winner SHALL be the requester pointed to by the round-robin pointer rr.
REQ-014 rr SHALL point to the non-winner after every accepted request, and SHALL be unchanged when no request is accepted.
REQ-015 The accepted address SHALL be registered: buf_avalid=1 and buf_addr=the accepted address exactly one cycle after acceptance; otherwise buf_avalid=0 and buf_addr holds its last value.
REQ-016 On each acceptance, the requester id SHALL be pushed into an in-order tag FIFO of depth C_MAX_OUTSTANDING.
REQ-017 occ SHALL be a counter of width log2(C_MAX_OUTSTANDING)+1 that increments on acceptance and decrements on a return.
REQ-018 occ SHALL be unchanged when an acceptance and a return occur in the same cycle.
REQ-019 While occ == C_MAX_OUTSTANDING, both aready outputs SHALL be 0, even if a return occurs in the same cycle.
REQ-020 On buf_valid=1 with occ>0, the block SHALL pop the tag FIFO and register buf_data to the tagged requester.
REQ-021 The tagged requester's reqN_valid SHALL be 1 one cycle after buf_valid, and the other requester's valid SHALL be 0.
REQ-022 reqN_data SHALL hold its value whenever reqN_valid=0.
REQ-023 On buf_valid=1 with occ=0, the return SHALL be dropped, no reqN_valid SHALL assert, and err_unexp SHALL be set to 1 until reset.
REQ-024 Requesters cannot stall returns; each reqN_valid pulse SHALL last exactly one cycle per return.
REQ-025 Back-to-back acceptances and back-to-back returns at one per cycle SHALL be sustained.

Reset
REQ-030 While areset=1, the block SHALL drive:
- buf_avalid=0, buf_addr=0.
- req0_valid=0, req1_valid=0, req0_data=0, req1_data=0.
- req0_aready=0, req1_aready=0.
- err_unexp=0, grant_cnt0=0, grant_cnt1=0.
REQ-031 While areset=1, internal state SHALL be cleared: occ=0, tag FIFO empty, rr=0 (requester 0 first).
REQ-032 A reset during traffic SHALL discard all outstanding tags; later stray returns SHALL be handled per REQ-023.

Configuration
REQ-040 The performance counters SHALL be compiled in or out with macro GNN_BUF_RD_ARB_PERF_EN.
REQ-041 With GNN_BUF_RD_ARB_PERF_EN defined, grant_cntN SHALL increment by 1 on each requester-N acceptance and saturate at 32'hFFFF_FFFF.
REQ-042 Without GNN_BUF_RD_ARB_PERF_EN, grant_cnt0 and grant_cnt1 SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-050 Single requester: req0 addr 0x005, buffer latency 4 -> buf_avalid at cycle+1 with addr 0x005; req0_valid at cycle+6 with the buffer data; req1_valid stays 0.
REQ-051 Contention: both requesters hold avalid for 6 cycles from reset (addrs 0x010.., 0x100..) -> grants alternate 0,1,0,1,0,1; each requester receives 3 returns in order.
REQ-052 Saturation: C_MAX_OUTSTANDING=8, buffer stalls returns -> exactly 8 acceptances, then both aready=0; releasing one return re-enables aready the next cycle.
REQ-053 Same-cycle acceptance and return at occ=8-1 -> occ stays 7; tag order is preserved.
REQ-054 Stray return: buf_valid=1 after reset with nothing outstanding -> no reqN_valid; err_unexp=1 until the next areset.
REQ-055 Run 3 acceptances for req0 and 2 for req1, once with GNN_BUF_RD_ARB_PERF_EN defined and once without -> with the macro, grant_cnt0=3 and grant_cnt1=2; without it, both read 0.
